// File: rtl/sent_pkg.sv
// Shared SENT transmitter types and timing constants.
package sent_pkg;

  localparam int unsigned SENT_SYNC_TICKS = 56;
  localparam int unsigned SENT_LOW_TICKS  = 5;
  localparam int unsigned SENT_NIB_OFFSET = 12;
  localparam int unsigned SENT_PAUSE_MIN  = 12;

  typedef enum logic [2:0] {
    StIdle,
    StCrcReq,
    StCrcWait,
    StSync,
    StStatus,
    StData,
    StCrc,
    StPause
  } sent_state_e;

  // Total pulse length in ticks for a nibble value.
  function automatic logic [11:0] nib_ticks(input logic [3:0] nib);
    return 12'(SENT_NIB_OFFSET) + {8'h00, nib};
  endfunction

  function automatic logic [11:0] pause_len(input logic [11:0] ticks);
    return (ticks < 12'(SENT_PAUSE_MIN)) ? 12'(SENT_PAUSE_MIN) : ticks;
  endfunction

endpackage

// File: rtl/sent_tick_gen.sv
// SENT tick divider: tick is high for one clk every tick_div+1 clks, realigned by restart.
module sent_tick_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic [15:0] tick_div,
  output logic        tick
);

  logic [15:0] cnt_q;

  assign tick = (cnt_q == tick_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q >= tick_div)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/sent_tx_frame.sv
// SENT frame transmitter: fetches the frame CRC, then emits sync, status, data nibbles, CRC and
// an optional pause pulse on sent_out.
module sent_tx_frame
  import sent_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_req,
  input  logic [2:0]  frame_len,
  input  logic [27:0] frame_data,
  input  logic [3:0]  frame_status,
  input  logic [15:0] tick_div,
  input  logic        pause_en,
  input  logic [11:0] pause_ticks,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        crc_req,
  output logic [2:0]  crc_len,
  output logic [27:0] crc_data,
  input  logic        crc_ack,
  input  logic [3:0]  crc_in,
  output logic        sent_out
);

  sent_state_e state_q;
  logic [2:0]  nib_left_q;
  logic [27:0] data_sh_q;
  logic [3:0]  status_q;
  logic [3:0]  crc_q;
  logic [15:0] div_q;
  logic        pause_en_q;
  logic [11:0] pause_ticks_q;
  logic [11:0] tick_cnt_q;

  logic        tick;
  logic        restart;
  logic        in_pulse;
  logic        pulse_end;
  logic [11:0] pulse_len;
  logic [2:0]  len_eff;

  assign len_eff = (frame_len == 3'd0) ? 3'd1 : frame_len;
  assign restart = (state_q == StCrcWait) && crc_ack;

  sent_tick_gen u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .restart  (restart),
    .tick_div (div_q),
    .tick     (tick)
  );

  always_comb begin
    in_pulse  = 1'b1;
    pulse_len = 12'(SENT_SYNC_TICKS);
    case (state_q)
      StSync:   pulse_len = 12'(SENT_SYNC_TICKS);
      StStatus: pulse_len = nib_ticks(status_q);
      StData:   pulse_len = nib_ticks(data_sh_q[27:24]);
      StCrc:    pulse_len = nib_ticks(crc_q);
      StPause:  pulse_len = pause_len(pause_ticks_q);
      default:  in_pulse  = 1'b0;
    endcase
    pulse_end = in_pulse && tick && (tick_cnt_q == (pulse_len - 12'd1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      nib_left_q    <= '0;
      data_sh_q     <= '0;
      status_q      <= '0;
      crc_q         <= '0;
      div_q         <= '0;
      pause_en_q    <= 1'b0;
      pause_ticks_q <= '0;
      tick_cnt_q    <= '0;
      sent_out      <= 1'b1;
      frame_busy    <= 1'b0;
      frame_done    <= 1'b0;
      crc_req       <= 1'b0;
      crc_len       <= '0;
      crc_data      <= '0;
    end else begin
      frame_done <= 1'b0;
      crc_req    <= 1'b0;
      // sent_out trails the pulse state by one clk, so consecutive pulses abut seamlessly.
      sent_out   <= !in_pulse || (tick_cnt_q >= 12'(SENT_LOW_TICKS));
      if (in_pulse && tick) begin
        tick_cnt_q <= pulse_end ? 12'd0 : tick_cnt_q + 12'd1;
      end

      case (state_q)
        StIdle: begin
          if (frame_busy) begin
            // Tail cycle: the final pulse is still on sent_out during this clk.
            frame_busy <= 1'b0;
            frame_done <= 1'b1;
          end else if (frame_req) begin
            nib_left_q    <= len_eff;
            data_sh_q     <= frame_data;
            status_q      <= frame_status;
            div_q         <= tick_div;
            pause_en_q    <= pause_en;
            pause_ticks_q <= pause_ticks;
            crc_len       <= len_eff;
            crc_data      <= frame_data;
            crc_req       <= 1'b1;
            frame_busy    <= 1'b1;
            state_q       <= StCrcReq;
          end
        end
        StCrcReq: state_q <= StCrcWait;
        StCrcWait: begin
          if (crc_ack) begin
            crc_q      <= crc_in;
            tick_cnt_q <= '0;
            state_q    <= StSync;
          end
        end
        StSync: begin
          if (pulse_end) state_q <= StStatus;
        end
        StStatus: begin
          if (pulse_end) state_q <= StData;
        end
        StData: begin
          if (pulse_end) begin
            data_sh_q  <= {data_sh_q[23:0], 4'h0};
            nib_left_q <= nib_left_q - 3'd1;
            if (nib_left_q == 3'd1) state_q <= StCrc;
          end
        end
        StCrc: begin
          if (pulse_end) state_q <= pause_en_q ? StPause : StIdle;
        end
        StPause: begin
          if (pulse_end) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sent_tx_frame.sv
// Directed bench for sent_tx_frame: measures sent_out pulse widths against hand-computed values.
module tb_sent_tx_frame;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_req = 1'b0;
  logic [2:0]  frame_len = '0;
  logic [27:0] frame_data = '0;
  logic [3:0]  frame_status = '0;
  logic [15:0] tick_div = '0;
  logic        pause_en = 1'b0;
  logic [11:0] pause_ticks = '0;
  logic        frame_busy, frame_done, crc_req, sent_out;
  logic [2:0]  crc_len;
  logic [27:0] crc_data;
  logic        crc_ack = 1'b0;
  logic [3:0]  crc_in = '0;

  int tot = 0;
  int bad = 0;

  int lows[$];
  int highs[$];
  int done_cnt, busy_cyc, crcreq_cnt, first_low_c, ack_c;
  bit timed_out, chain_ok;
  logic [2:0]  crc_len_s;
  logic [27:0] crc_data_s;
  logic ab_pre, ab_out, ab_busy, ab_crcreq;
  logic [2:0]  ab_len;
  logic [27:0] ab_data;

  sent_tx_frame dut (
    .clk          (clk),
    .rst          (rst),
    .frame_req    (frame_req),
    .frame_len    (frame_len),
    .frame_data   (frame_data),
    .frame_status (frame_status),
    .tick_div     (tick_div),
    .pause_en     (pause_en),
    .pause_ticks  (pause_ticks),
    .frame_busy   (frame_busy),
    .frame_done   (frame_done),
    .crc_req      (crc_req),
    .crc_len      (crc_len),
    .crc_data     (crc_data),
    .crc_ack      (crc_ack),
    .crc_in       (crc_in),
    .sent_out     (sent_out)
  );

  always #5 clk = ~clk;

  // Issues one frame, answers the CRC request and records low/high run lengths of sent_out
  // while frame_busy is high. Sampling is on the falling clock edge.
  task automatic run_frame(input logic [2:0] len, input logic [27:0] data,
                           input logic [3:0] status, input logic [15:0] div, input logic pen,
                           input logic [11:0] pt, input int ack_delay, input logic [3:0] crcv,
                           input bit early_ack, input int extra_req_c, input int abort_c,
                           input bit chain);
    int ack_at = -1;
    int run = 0;
    int post = -1;
    logic cur = 1'b1;
    logic prev_busy = 1'b0;
    bit finished = 0;
    bit chain_pend = 0;
    lows.delete();
    highs.delete();
    done_cnt = 0; busy_cyc = 0; crcreq_cnt = 0; first_low_c = -1; ack_c = -1;
    timed_out = 0; chain_ok = 0;
    @(negedge clk);
    frame_len = len; frame_data = data; frame_status = status; tick_div = div;
    pause_en = pen; pause_ticks = pt; frame_req = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      frame_req = (c == extra_req_c);
      crc_ack = 1'b0;
      if (chain_pend) begin
        chain_ok = crc_req;
        chain_pend = 0;
      end
      if (crc_req) begin
        crcreq_cnt++;
        if (c == 0) begin
          crc_len_s = crc_len;
          crc_data_s = crc_data;
        end
        if (ack_at < 0) ack_at = c + 1 + ack_delay;
      end
      if (c == 0) begin
        // Inputs change after accept; the frame must use the captured copies.
        frame_len = ~len; frame_data = ~data; frame_status = ~status;
        tick_div = div + 16'd2; pause_en = ~pen; pause_ticks = ~pt;
        if (early_ack) begin
          crc_ack = 1'b1;
          crc_in = crcv ^ 4'hF;
        end
      end
      if (c == ack_at) begin
        crc_ack = 1'b1;
        crc_in = crcv;
        ack_c = c;
      end
      if (c == abort_c) begin
        ab_pre = sent_out;
        #2 rst = 1'b1;
        #1;
        ab_out = sent_out; ab_busy = frame_busy; ab_crcreq = crc_req;
        ab_len = crc_len; ab_data = crc_data;
        crc_ack = 1'b0;
        finished = 1;
        break;
      end
      if (frame_busy) begin
        busy_cyc++;
        if (first_low_c < 0) begin
          if (!sent_out) begin
            first_low_c = c;
            cur = 1'b0;
            run = 1;
          end
        end else if (sent_out == cur) begin
          run++;
        end else begin
          if (cur) highs.push_back(run);
          else lows.push_back(run);
          cur = sent_out;
          run = 1;
        end
      end else if (prev_busy && first_low_c >= 0) begin
        if (cur) highs.push_back(run);
        else lows.push_back(run);
      end
      prev_busy = frame_busy;
      if (frame_done) begin
        done_cnt++;
        if (post < 0) post = 6;
        if (chain) begin
          frame_req = 1'b1;
          chain_pend = 1;
        end
      end
      if (post > 0) begin
        post--;
        if (post == 0) begin
          finished = 1;
          break;
        end
      end
    end
    crc_ack = 1'b0;
    frame_req = 1'b0;
    if (!finished) timed_out = 1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tot++;
    if (sent_out !== 1'b1 || frame_busy !== 1'b0 || frame_done !== 1'b0 || crc_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl got out=%b busy=%b done=%b req=%b want 1/0/0/0",
               sent_out, frame_busy, frame_done, crc_req);
    end
    tot++;
    if (crc_len !== 3'd0 || crc_data !== 28'd0) begin
      bad++;
      $display("FAIL reset_crc_bus got len=%0d data=%h want 0/0", crc_len, crc_data);
    end
    rst = 1'b0;
    // crc_ack in IDLE must not start anything.
    @(negedge clk);
    crc_ack = 1'b1;
    crc_in = 4'hF;
    @(negedge clk);
    crc_ack = 1'b0;
    repeat (3) @(negedge clk);
    tot++;
    if (sent_out !== 1'b1 || frame_busy !== 1'b0 || crc_req !== 1'b0) begin
      bad++;
      $display("FAIL idle_ack got out=%b busy=%b req=%b want 1/0/0", sent_out, frame_busy, crc_req);
    end
  endtask

  task automatic test_basic();
    int eh[4] = '{51, 7, 7, 12};
    run_frame(3'd1, 28'h0, 4'h0, 16'd0, 1'b0, 12'd0, 0, 4'h5, 0, -1, -1, 0);
    tot++;
    if (timed_out || done_cnt !== 1) begin
      bad++;
      $display("FAIL basic_done got count=%0d timeout=%0d want 1/0", done_cnt, timed_out);
    end
    tot++;
    if (lows.size() !== 4 || highs.size() !== 4) begin
      bad++;
      $display("FAIL basic_npulse got=%0d/%0d want=4/4", lows.size(), highs.size());
    end
    for (int i = 0; i < 4; i++) begin
      tot++;
      if (i >= lows.size() || i >= highs.size() || lows[i] !== 5 || highs[i] !== eh[i]) begin
        bad++;
        $display("FAIL basic_pulse%0d got low/high=%0d/%0d want 5/%0d", i,
                 (i < lows.size()) ? lows[i] : -1, (i < highs.size()) ? highs[i] : -1, eh[i]);
      end
    end
    tot++;
    if (busy_cyc !== 100) begin
      bad++;
      $display("FAIL basic_busy got=%0d want=100", busy_cyc);
    end
    tot++;
    if (ack_c !== 1 || first_low_c !== 3) begin
      bad++;
      $display("FAIL basic_sync_start got ack=%0d low=%0d want 1/3", ack_c, first_low_c);
    end
  endtask

  task automatic test_div3();
    int eh[4] = '{204, 28, 28, 48};
    run_frame(3'd1, 28'h0, 4'h0, 16'd3, 1'b0, 12'd0, 0, 4'h5, 0, -1, -1, 0);
    tot++;
    if (timed_out || done_cnt !== 1 || lows.size() !== 4 || highs.size() !== 4) begin
      bad++;
      $display("FAIL div3_frame got done=%0d pulses=%0d want 1/4", done_cnt, highs.size());
    end
    tot++;
    if (lows.size() < 1 || highs.size() < 1 || lows[0] !== 20 || lows[0] + highs[0] !== 224) begin
      bad++;
      $display("FAIL div3_sync got low=%0d total=%0d want 20/224",
               (lows.size() > 0) ? lows[0] : -1,
               (lows.size() > 0 && highs.size() > 0) ? lows[0] + highs[0] : -1);
    end
    for (int i = 1; i < 4; i++) begin
      tot++;
      if (i >= lows.size() || i >= highs.size() || lows[i] !== 20 || highs[i] !== eh[i]) begin
        bad++;
        $display("FAIL div3_pulse%0d got low/high=%0d/%0d want 20/%0d", i,
                 (i < lows.size()) ? lows[i] : -1, (i < highs.size()) ? highs[i] : -1, eh[i]);
      end
    end
    tot++;
    if (busy_cyc !== 391) begin
      bad++;
      $display("FAIL div3_busy got=%0d want=391", busy_cyc);
    end
  endtask

  task automatic test_pause();
    int eh[5] = '{51, 7, 7, 12, 7};
    for (int r = 0; r < 2; r++) begin
      eh[4] = (r == 0) ? 7 : 95;
      run_frame(3'd1, 28'h0, 4'h0, 16'd0, 1'b1, (r == 0) ? 12'd8 : 12'd100, 0, 4'h5, 0, -1, -1,
                0);
      tot++;
      if (timed_out || done_cnt !== 1 || lows.size() !== 5 || highs.size() !== 5) begin
        bad++;
        $display("FAIL pause%0d_frame got done=%0d pulses=%0d want 1/5", r, done_cnt,
                 highs.size());
      end
      for (int i = 0; i < 5; i++) begin
        tot++;
        if (i >= lows.size() || i >= highs.size() || lows[i] !== 5 || highs[i] !== eh[i]) begin
          bad++;
          $display("FAIL pause%0d_pulse%0d got low/high=%0d/%0d want 5/%0d", r, i,
                   (i < lows.size()) ? lows[i] : -1, (i < highs.size()) ? highs[i] : -1, eh[i]);
        end
      end
    end
  endtask

  task automatic test_crc_delay();
    int eh[4] = '{51, 9, 14, 8};
    run_frame(3'd1, 28'h7000000, 4'h2, 16'd0, 1'b0, 12'd0, 10, 4'h1, 0, 40, -1, 0);
    tot++;
    if (ack_c !== 11 || first_low_c !== 13) begin
      bad++;
      $display("FAIL delay_sync_start got ack=%0d low=%0d want 11/13", ack_c, first_low_c);
    end
    tot++;
    if (timed_out || done_cnt !== 1 || crcreq_cnt !== 1) begin
      bad++;
      $display("FAIL delay_single_frame got done=%0d crc_req=%0d want 1/1", done_cnt, crcreq_cnt);
    end
    tot++;
    if (crc_len_s !== 3'd1 || crc_data_s !== 28'h7000000) begin
      bad++;
      $display("FAIL delay_crc_bus got len=%0d data=%h want 1/7000000", crc_len_s, crc_data_s);
    end
    for (int i = 0; i < 4; i++) begin
      tot++;
      if (i >= lows.size() || i >= highs.size() || lows[i] !== 5 || highs[i] !== eh[i]) begin
        bad++;
        $display("FAIL delay_pulse%0d got low/high=%0d/%0d want 5/%0d", i,
                 (i < lows.size()) ? lows[i] : -1, (i < highs.size()) ? highs[i] : -1, eh[i]);
      end
    end
    tot++;
    if (busy_cyc !== 115) begin
      bad++;
      $display("FAIL delay_busy got=%0d want=115", busy_cyc);
    end
  endtask

  task automatic test_nibbles();
    int eh[6] = '{102, 34, 16, 44, 18, 20};
    run_frame(3'd3, 28'h1F20000, 4'hA, 16'd1, 1'b0, 12'd0, 2, 4'h3, 1, -1, -1, 0);
    tot++;
    if (timed_out || done_cnt !== 1 || lows.size() !== 6 || highs.size() !== 6) begin
      bad++;
      $display("FAIL nib_frame got done=%0d pulses=%0d want 1/6", done_cnt, highs.size());
    end
    tot++;
    if (crc_len_s !== 3'd3 || crc_data_s !== 28'h1F20000) begin
      bad++;
      $display("FAIL nib_crc_bus got len=%0d data=%h want 3/1f20000", crc_len_s, crc_data_s);
    end
    for (int i = 0; i < 6; i++) begin
      tot++;
      if (i >= lows.size() || i >= highs.size() || lows[i] !== 10 || highs[i] !== eh[i]) begin
        bad++;
        $display("FAIL nib_pulse%0d got low/high=%0d/%0d want 10/%0d", i,
                 (i < lows.size()) ? lows[i] : -1, (i < highs.size()) ? highs[i] : -1, eh[i]);
      end
    end
  endtask

  task automatic test_len0();
    int eh[4] = '{51, 7, 16, 7};
    run_frame(3'd0, 28'h9000000, 4'h0, 16'd0, 1'b0, 12'd0, 0, 4'h0, 0, -1, -1, 0);
    tot++;
    if (crc_len_s !== 3'd1) begin
      bad++;
      $display("FAIL len0_crc_len got=%0d want=1", crc_len_s);
    end
    tot++;
    if (timed_out || done_cnt !== 1 || lows.size() !== 4 || highs.size() !== 4) begin
      bad++;
      $display("FAIL len0_frame got done=%0d pulses=%0d want 1/4", done_cnt, highs.size());
    end
    for (int i = 0; i < 4; i++) begin
      tot++;
      if (i >= lows.size() || i >= highs.size() || lows[i] !== 5 || highs[i] !== eh[i]) begin
        bad++;
        $display("FAIL len0_pulse%0d got low/high=%0d/%0d want 5/%0d", i,
                 (i < lows.size()) ? lows[i] : -1, (i < highs.size()) ? highs[i] : -1, eh[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_frame(3'd1, 28'h0, 4'h0, 16'd0, 1'b0, 12'd0, 0, 4'h5, 0, -1, -1, 1);
    tot++;
    if (done_cnt !== 1 || highs.size() !== 4) begin
      bad++;
      $display("FAIL b2b_first got done=%0d pulses=%0d want 1/4", done_cnt, highs.size());
    end
    tot++;
    if (chain_ok !== 1'b1 || crcreq_cnt !== 2) begin
      bad++;
      $display("FAIL b2b_accept got chained_req=%0d crc_reqs=%0d want 1/2", chain_ok, crcreq_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int eh[6] = '{51, 7, 8, 9, 10, 7};
    bit saw_done = 0;
    bit saw_low = 0;
    run_frame(3'd3, 28'h1230000, 4'h0, 16'd0, 1'b0, 12'd0, 0, 4'h0, 0, -1, 75, 0);
    tot++;
    if (ab_pre !== 1'b0 || done_cnt !== 0) begin
      bad++;
      $display("FAIL abort_pre got out=%b done=%0d want 0/0", ab_pre, done_cnt);
    end
    tot++;
    if (ab_out !== 1'b1 || ab_busy !== 1'b0 || ab_crcreq !== 1'b0) begin
      bad++;
      $display("FAIL abort_async got out=%b busy=%b req=%b want 1/0/0", ab_out, ab_busy, ab_crcreq);
    end
    tot++;
    if (ab_len !== 3'd0 || ab_data !== 28'd0) begin
      bad++;
      $display("FAIL abort_crc_bus got len=%0d data=%h want 0/0", ab_len, ab_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (frame_done) saw_done = 1;
      if (!sent_out) saw_low = 1;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (frame_done) saw_done = 1;
      if (!sent_out) saw_low = 1;
    end
    tot++;
    if (saw_done || saw_low) begin
      bad++;
      $display("FAIL abort_quiet got done_seen=%0d low_seen=%0d want 0/0", saw_done, saw_low);
    end
    run_frame(3'd3, 28'h1230000, 4'h0, 16'd0, 1'b0, 12'd0, 0, 4'h0, 0, -1, -1, 0);
    tot++;
    if (timed_out || done_cnt !== 1 || lows.size() !== 6 || highs.size() !== 6) begin
      bad++;
      $display("FAIL abort_next_frame got done=%0d pulses=%0d want 1/6", done_cnt, highs.size());
    end
    for (int i = 0; i < 6; i++) begin
      tot++;
      if (i >= lows.size() || i >= highs.size() || lows[i] !== 5 || highs[i] !== eh[i]) begin
        bad++;
        $display("FAIL abort_next_pulse%0d got low/high=%0d/%0d want 5/%0d", i,
                 (i < lows.size()) ? lows[i] : -1, (i < highs.size()) ? highs[i] : -1, eh[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div3();
    test_pause();
    test_crc_delay();
    test_nibbles();
    test_len0();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/sent_tx_frame.md
SENT_TX_FRAME -- requirements
Module: sent_tx_frame

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have ports: frame_req  in  1  one-cycle frame start request; frame_len  in  3  data-nibble count; frame_data  in  28  data nibbles, first at [27:24]; frame_status  in  4  status nibble; tick_div  in  16  clk cycles per SENT tick minus 1.
REQ-003 SHALL have ports: pause_en  in  1  append pause pulse; pause_ticks  in  12  pause length in ticks; frame_busy  out  1  frame in progress; frame_done  out  1  one-cycle completion pulse.
REQ-004 SHALL have ports: crc_req  out  1  CRC request to sent_crc; crc_len  out  3  nibble count; crc_data  out  28  data; crc_ack  in  1  CRC done; crc_in  in  4  CRC result; sent_out  out  1  SENT line, idle high.

Function
REQ-005 SHALL accept frame_req only in IDLE and ignore it in all other states.
REQ-006 On accept SHALL capture frame_len, frame_data, frame_status, tick_div, pause_en and pause_ticks; frame_len 0 SHALL be treated as 1.
REQ-007 SHALL drive crc_req high for exactly the cycle after accept, with crc_len/crc_data holding the captured values, then enter CRC_WAIT.
REQ-008 In CRC_WAIT SHALL capture crc_in on the crc_ack cycle and enter SYNC on the next cycle; sent_out SHALL stay high while waiting, with no timeout.
REQ-009 States SHALL be IDLE, CRC_REQ, CRC_WAIT, SYNC, STATUS, DATA, CRC, PAUSE; the sequence SHALL be SYNC -> STATUS -> DATA (x frame_len) -> CRC -> PAUSE (if pause_en) -> IDLE.
REQ-010 Tick strobe SHALL pulse every tick_div+1 clk cycles; the divider SHALL restart on SYNC entry.
REQ-011 Each pulse SHALL be 5 ticks low, then high for the remainder; pulse lengths SHALL be SYNC 56 ticks, nibble pulse 12+value ticks, and PAUSE max(pause_ticks,12) ticks.
REQ-012 Nibble counter SHALL step through frame_data from [27:24] downward for frame_len nibbles.
REQ-013 sent_out SHALL be registered and fall one clk after SYNC entry; consecutive pulses SHALL abut with no gap cycles.
REQ-014 frame_busy SHALL be high from the accept cycle through the last cycle of the final pulse.
REQ-015 frame_done SHALL pulse for one cycle on the cycle frame_busy falls; the next frame_req SHALL be accepted on that same cycle or later.
REQ-016 A crc_ack outside CRC_WAIT SHALL be ignored.

Reset
REQ-017 rst SHALL immediately force IDLE, sent_out=1, frame_busy=0, frame_done=0, crc_req=0, crc_len=0, crc_data=0, and clear all counters.
REQ-018 rst asserted mid-frame SHALL abort the frame without asserting frame_done.

Structure
REQ-019 Package sent_pkg SHALL hold the state enum and constants SENT_SYNC_TICKS=56, SENT_LOW_TICKS=5, SENT_NIB_OFFSET=12, SENT_PAUSE_MIN=12.
REQ-020 Tick generation SHALL be a sub-module sent_tick_gen (clk, rst, restart, tick_div, tick).

Verification
REQ-021 tick_div=0, len=1, data[27:24]=0, status=0, crc_in=5 -> low/high pulse widths in clk: 5/51, 5/7, 5/7, 5/12; frame_done once.
REQ-022 tick_div=3, same frame -> sync low 20 clk, sync total 224 clk; frame_busy spans the whole frame.
REQ-023 pause_en=1, pause_ticks=8 -> pause pulse 12 ticks; pause_ticks=100 -> 100 ticks.
REQ-024 crc_ack delayed 10 cycles -> sent_out high throughout; SYNC starts 1 clk after ack; frame_req pulsed while busy -> ignored, exactly one frame sent.
REQ-025 rst asserted during DATA -> sent_out=1 asynchronously, no frame_done; a new frame_req afterwards -> complete, correct frame.
